// File: rtl/boot_loader.sv
// Byte-stream program loader: parses A5-framed UART bytes into 32-bit words,
// writes them to consecutive memory addresses and releases the CPU on a good checksum.
module boot_loader #(
   parameter int unsigned ADDR_W        = 15,
   parameter int unsigned BASE_ADDR     = 0,
   parameter int unsigned TIMEOUT       = 1000000,
   parameter bit          HOLD_AT_RESET = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_rw,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CSUM, DONE, ERROR} state_t;

   localparam int unsigned MAX_WORDS = 1 << ADDR_W;
   localparam logic [7:0]  SYNC      = 8'hA5;

   state_t            r_state;
   state_t            w_stateNext;
   logic [7:0]        r_cntLo;
   logic [15:0]       r_count;
   logic [15:0]       r_wordIdx;
   logic [1:0]        r_byteIdx;
   logic [23:0]       r_word;
   logic [7:0]        r_csum;
   logic [31:0]       r_idleCnt;
   logic [ADDR_W-1:0] r_memAddr;
   logic [31:0]       r_memWdata;
   logic              r_memRw;
   logic              r_cpuHold;
   logic              r_done;
   logic              r_error;

   logic              w_accept;
   logic              w_active;
   logic [15:0]       w_count;
   logic              w_tooLong;
   logic              w_lastByte;
   logic              w_lastWord;
   logic [31:0]       w_idleNext;
   logic              w_timeout;

   // The write cycle is the only cycle the loader refuses a byte.
   assign in_ready   = r_memRw;
   assign w_accept   = in_valid & r_memRw;
   assign w_active   = (r_state == CNT_LO) || (r_state == CNT_HI) ||
                       (r_state == DATA)   || (r_state == CSUM);
   assign w_count    = {in_data, r_cntLo};
   assign w_tooLong  = 32'(w_count) > MAX_WORDS;
   assign w_lastByte = (r_byteIdx == 2'd3);
   assign w_lastWord = (r_wordIdx == (r_count - 16'd1));
   assign w_idleNext = r_idleCnt + 32'd1;
   // An accepted byte always beats an expiring timeout.
   assign w_timeout  = (TIMEOUT != 0) && w_active && !w_accept &&
                       (w_idleNext == 32'(TIMEOUT));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= IDLE;
      else        r_state <= w_stateNext;
   end

   always_comb begin
      w_stateNext = r_state;
      if (w_timeout) begin
         w_stateNext = ERROR;
      end else if (w_accept) begin
         case (r_state)
            IDLE, DONE, ERROR: if (in_data == SYNC) w_stateNext = CNT_LO;
            CNT_LO:            w_stateNext = CNT_HI;
            CNT_HI: begin
               if (w_tooLong)            w_stateNext = ERROR;
               else if (w_count == 16'd0) w_stateNext = CSUM;
               else                       w_stateNext = DATA;
            end
            DATA:              if (w_lastByte && w_lastWord) w_stateNext = CSUM;
            CSUM:              w_stateNext = (in_data == r_csum) ? DONE : ERROR;
            default:           w_stateNext = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cntLo    <= 8'h00;
         r_count    <= 16'h0000;
         r_wordIdx  <= 16'h0000;
         r_byteIdx  <= 2'd0;
         r_word     <= 24'h000000;
         r_csum     <= 8'h00;
         r_idleCnt  <= 32'd0;
         r_memAddr  <= ADDR_W'(BASE_ADDR);
         r_memWdata <= 32'h0000_0000;
         r_memRw    <= 1'b1;
         r_cpuHold  <= HOLD_AT_RESET;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         r_memRw   <= 1'b1;
         r_idleCnt <= (w_active && !w_accept && !w_timeout) ? w_idleNext : 32'd0;
         if (w_timeout) begin
            r_cpuHold <= 1'b1;
            r_done    <= 1'b0;
            r_error   <= 1'b1;
         end else if (w_accept) begin
            case (r_state)
               IDLE, DONE, ERROR: begin
                  if (in_data == SYNC) begin
                     r_cpuHold <= 1'b1;
                     r_done    <= 1'b0;
                     r_error   <= 1'b0;
                     r_csum    <= 8'h00;
                     r_byteIdx <= 2'd0;
                     r_wordIdx <= 16'h0000;
                  end
               end
               CNT_LO: r_cntLo <= in_data;
               CNT_HI: begin
                  r_count   <= w_count;
                  r_byteIdx <= 2'd0;
                  r_wordIdx <= 16'h0000;
                  if (w_tooLong) r_error <= 1'b1;
               end
               DATA: begin
                  r_csum <= r_csum ^ in_data;
                  if (w_lastByte) begin
                     r_memRw    <= 1'b0;
                     r_memWdata <= {in_data, r_word};
                     r_memAddr  <= ADDR_W'(BASE_ADDR + 32'(r_wordIdx));
                     r_wordIdx  <= r_wordIdx + 16'd1;
                     r_byteIdx  <= 2'd0;
                  end else begin
                     case (r_byteIdx)
                        2'd0:    r_word[7:0]   <= in_data;
                        2'd1:    r_word[15:8]  <= in_data;
                        default: r_word[23:16] <= in_data;
                     endcase
                     r_byteIdx <= r_byteIdx + 2'd1;
                  end
               end
               CSUM: begin
                  if (in_data == r_csum) begin
                     r_cpuHold <= 1'b0;
                     r_done    <= 1'b1;
                  end else begin
                     r_cpuHold <= 1'b1;
                     r_error   <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;
   assign mem_rw    = r_memRw;
   assign cpu_hold  = r_cpuHold;
   assign done      = r_done;
   assign error     = r_error;

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed frames plus randomized frames
// compared against a frame-level reference model.
module tb_boot_loader;

   localparam int ADDR_W    = 15;
   localparam int BASE_ADDR = 0;
   localparam int TIMEOUT   = 16;
   localparam int MAX_WORDS = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              mem_rw;
   logic              cpu_hold;
   logic              done;
   logic              error;

   int                vectorCount = 0;
   int                missCount = 0;
   int                stallCount = 0;
   int                readyViolations = 0;
   int                longWrites = 0;
   bit                prevLow = 1'b0;
   logic [31:0]       wrAddrQ[$];
   logic [31:0]       wrDataQ[$];
   logic [7:0]        frameData[$];

   boot_loader #(
      .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .TIMEOUT(TIMEOUT), .HOLD_AT_RESET(1'b1)
   ) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
      .cpu_hold(cpu_hold), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   // Records every memory write and watches the one-cycle write / back-pressure rules.
   always @(negedge clk) begin
      if (reset) begin
         if (!mem_rw) begin
            wrAddrQ.push_back(32'(mem_addr));
            wrDataQ.push_back(mem_wdata);
         end
         if (in_ready !== mem_rw) readyViolations++;
         if (!mem_rw && prevLow) longWrites++;
         prevLow = !mem_rw;
      end else begin
         prevLow = 1'b0;
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, observed hang, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectorCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Offers one byte and holds it until the loader takes it; returns on the following negedge.
   task automatic sendByte(input logic [7:0] b);
      int waits;
      waits    = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && waits < 20) begin
         stallCount++;
         @(negedge clk);
         waits++;
      end
      if (!in_ready) checkOutput("readyWait", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idleCycles(input int k);
      in_valid = 1'b0;
      repeat (k) @(negedge clk);
   endtask

   task automatic clearCapture();
      wrAddrQ.delete();
      wrDataQ.delete();
      stallCount = 0;
   endtask

   task automatic checkStatus(input string tag, input bit expDone, input bit expError, input bit expHold);
      checkOutput({tag, ".done"}, 32'(done), 32'(expDone));
      checkOutput({tag, ".error"}, 32'(error), 32'(expError));
      checkOutput({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(expHold));
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
      checkOutput({tag, ".mem_rw"}, 32'(mem_rw), 32'd1);
      checkOutput({tag, ".mem_addr"}, 32'(mem_addr), 32'(BASE_ADDR));
      checkOutput({tag, ".mem_wdata"}, mem_wdata, 32'd0);
      checkStatus(tag, 1'b0, 1'b0, 1'b1);
   endtask

   function automatic logic [7:0] refChecksum();
      logic [7:0] c;
      c = 8'h00;
      foreach (frameData[i]) c = c ^ frameData[i];
      return c;
   endfunction

   task automatic randomFrame(input int n);
      frameData.delete();
      for (int i = 0; i < 4 * n; i++) frameData.push_back(8'($urandom_range(0, 255)));
   endtask

   // Sends A5 | N | frameData | csum and checks the writes and final status the frame must produce.
   task automatic applyStimulus(input int n, input logic [7:0] csum, input int maxGap);
      logic [15:0] cnt;
      bit          good;
      logic [7:0]  hdr[$];
      cnt  = 16'(n);
      good = (csum == refChecksum());
      clearCapture();
      hdr = '{8'hA5, cnt[7:0], cnt[15:8]};
      foreach (frameData[i]) hdr.push_back(frameData[i]);
      hdr.push_back(csum);
      foreach (hdr[i]) begin
         sendByte(hdr[i]);
         if (maxGap > 0) idleCycles($urandom_range(0, maxGap));
      end
      in_valid = 1'b0;
      checkStatus("frame", good, !good, !good);
      checkOutput("wrCount", 32'(wrAddrQ.size()), 32'(n));
      for (int i = 0; i < n && i < wrAddrQ.size(); i++) begin
         checkOutput("wrAddr", wrAddrQ[i], 32'((BASE_ADDR + i) % MAX_WORDS));
         checkOutput("wrData", wrDataQ[i],
                     {frameData[4*i+3], frameData[4*i+2], frameData[4*i+1], frameData[4*i]});
      end
      if (n > 0) checkOutput("addrHold", 32'(mem_addr), 32'((BASE_ADDR + n - 1) % MAX_WORDS));
      if (maxGap == 0) checkOutput("stalls", 32'(stallCount), 32'(n));
   endtask

   initial begin
      $display("[TB] boot_loader bench starting");
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      reset = 1'b1;
      @(negedge clk);

      // Junk bytes before a sync are swallowed without effect.
      clearCapture();
      sendByte(8'h00);
      sendByte(8'hFF);
      sendByte(8'h12);
      in_valid = 1'b0;
      checkOutput("junk.in_ready", 32'(in_ready), 32'd1);
      checkStatus("junk", 1'b0, 1'b0, 1'b1);
      checkOutput("junk.wrCount", 32'(wrAddrQ.size()), 32'd0);

      // Two-word frame with valid held across word boundaries (checksum of these bytes is 0x09).
      frameData = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      applyStimulus(2, refChecksum(), 0);
      applyStimulus(2, 8'h00, 1);

      frameData.delete();
      applyStimulus(0, 8'h00, 0);

      clearCapture();
      sendByte(8'hA5);
      sendByte(8'h01);
      sendByte(8'h80);
      in_valid = 1'b0;
      checkStatus("tooLong", 1'b0, 1'b1, 1'b1);
      idleCycles(3);
      checkOutput("tooLong.wrCount", 32'(wrAddrQ.size()), 32'd0);

      // Idle timeout with a partial word pending.
      clearCapture();
      sendByte(8'hA5);
      sendByte(8'h01);
      sendByte(8'h00);
      sendByte(8'hAA);
      sendByte(8'hBB);
      idleCycles(TIMEOUT - 1);
      checkOutput("timeout.early", 32'(error), 32'd0);
      idleCycles(1);
      checkStatus("timeout", 1'b0, 1'b1, 1'b1);
      checkOutput("timeout.wrCount", 32'(wrAddrQ.size()), 32'd0);
      sendByte(8'hA5);
      in_valid = 1'b0;
      checkStatus("restart", 1'b0, 1'b0, 1'b1);
      sendByte(8'h00);
      sendByte(8'h00);
      sendByte(8'h00);
      in_valid = 1'b0;
      checkStatus("restartDone", 1'b1, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a word.
      randomFrame(2);
      applyStimulus(2, refChecksum(), 0);
      clearCapture();
      sendByte(8'hA5);
      sendByte(8'h02);
      sendByte(8'h00);
      sendByte(8'h11);
      sendByte(8'h22);
      in_valid = 1'b0;
      #2 reset = 1'b0;
      #1 checkResetValues("midReset");
      repeat (2) @(negedge clk);
      reset = 1'b1;
      idleCycles(2);
      checkOutput("midReset.wrCount", 32'(wrAddrQ.size()), 32'd0);
      randomFrame(3);
      applyStimulus(3, refChecksum(), 2);

      for (int k = 0; k < 20; k++) begin
         int         n;
         logic [7:0] csum;
         n = $urandom_range(0, 6);
         randomFrame(n);
         csum = refChecksum();
         if ($urandom_range(0, 3) == 0) csum = csum ^ 8'($urandom_range(1, 255));
         applyStimulus(n, csum, $urandom_range(0, 3));
      end

      checkOutput("readyRule", 32'(readyViolations), 32'd0);
      checkOutput("oneCycleWrite", 32'(longWrites), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
